// File: rtl/cnn_obi_mgr.sv
// OBI manager port for the CNN accelerator.
// Moves word streams between system memory and the datapath: read jobs fetch
// words over OBI into a small FIFO feeding rd_*; write jobs forward wr_* words
// to OBI stores. One job at a time; a command gives direction, base and length.
//
// Handshakes: every valid/ready pair (cmd, rd, wr) transfers exactly on a
// cycle where both valid and ready are 1 at the rising clock edge; a producer
// keeps valid and data stable until that transfer, and ready may depend on
// valid. OBI follows the same rule with req/gnt, and rvalid is a one-cycle
// response strobe that cannot be back-pressured.
module cnn_obi_mgr #(
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32,
    parameter int LEN_WIDTH  = 16,
    parameter int MAX_OUTST  = 2,
    parameter int FIFO_DEPTH = 4
) (
    input  logic                    clk_i,
    input  logic                    rst_ni,
    input  logic                    cmd_valid_i,
    output logic                    cmd_ready_o,
    input  logic                    cmd_we_i,
    input  logic [ADDR_WIDTH-1:0]   cmd_addr_i,
    input  logic [LEN_WIDTH-1:0]    cmd_len_i,
    output logic                    busy_o,
    output logic                    done_o,
    output logic                    err_o,
    output logic [DATA_WIDTH-1:0]   rd_data_o,
    output logic                    rd_valid_o,
    input  logic                    rd_ready_i,
    input  logic [DATA_WIDTH-1:0]   wr_data_i,
    input  logic                    wr_valid_i,
    output logic                    wr_ready_o,
    output logic                    obi_req_o,
    input  logic                    obi_gnt_i,
    output logic [ADDR_WIDTH-1:0]   obi_addr_o,
    output logic                    obi_we_o,
    output logic [DATA_WIDTH/8-1:0] obi_be_o,
    output logic [DATA_WIDTH-1:0]   obi_wdata_o,
    input  logic                    obi_rvalid_i,
    input  logic [DATA_WIDTH-1:0]   obi_rdata_i,
    input  logic                    obi_err_i,
    output logic [1:0]              dbg_state
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        DRAIN = 2'd2,
        DONE  = 2'd3
    } state_t;

    localparam int OW    = $clog2(MAX_OUTST + 1);
    localparam int PW    = $clog2(FIFO_DEPTH);
    localparam int CW    = $clog2(FIFO_DEPTH + 1);
    localparam int BYTES = DATA_WIDTH / 8;

    state_t                state, state_nxt;
    logic                  job_we;
    logic [ADDR_WIDTH-1:0] job_base;
    logic [LEN_WIDTH-1:0]  job_len;
    logic [LEN_WIDTH-1:0]  issued_cnt, issued_nxt;
    logic [OW-1:0]         outstanding, outst_nxt;
    logic [CW-1:0]         fifo_count;
    logic [PW-1:0]         wr_ptr, rd_ptr;
    logic [DATA_WIDTH-1:0] fifo_mem [FIFO_DEPTH];
    logic                  err_q;

    logic cmd_fire, gnt_fire, rsp_fire, push, pop;
    logic running, more_to_issue, outst_ok, credit_ok;

    assign cmd_fire      = cmd_valid_i && (state == IDLE);
    assign running       = (state == RUN);
    assign more_to_issue = issued_cnt < job_len;
    assign outst_ok      = 32'(outstanding) < 32'(MAX_OUTST);
    // Reads only ask when every in-flight response already owns a FIFO slot.
    assign credit_ok     = job_we || ((32'(outstanding) + 32'(fifo_count)) < 32'(FIFO_DEPTH));

    assign obi_req_o   = running && more_to_issue && outst_ok && credit_ok && (!job_we || wr_valid_i);
    assign obi_addr_o  = job_base + ADDR_WIDTH'(issued_cnt) * ADDR_WIDTH'(BYTES);
    assign obi_we_o    = job_we;
    assign obi_be_o    = {BYTES{obi_req_o}};
    assign obi_wdata_o = (running && job_we) ? wr_data_i : '0;

    assign gnt_fire   = obi_req_o && obi_gnt_i;
    assign rsp_fire   = obi_rvalid_i && (outstanding != '0);
    assign wr_ready_o = gnt_fire && job_we;
    assign push       = rsp_fire && !job_we;
    assign rd_valid_o = (fifo_count != '0);
    assign pop        = rd_valid_o && rd_ready_i;
    assign rd_data_o  = rd_valid_o ? fifo_mem[rd_ptr] : '0;
    assign err_o      = err_q;
    assign dbg_state  = state;

    assign issued_nxt = issued_cnt + LEN_WIDTH'(gnt_fire);

    // Outstanding count after this cycle's grant and response.
    always_comb begin
        outst_nxt = outstanding;
        if (gnt_fire && !rsp_fire)      outst_nxt = outstanding + OW'(1);
        else if (!gnt_fire && rsp_fire) outst_nxt = outstanding - OW'(1);
    end

    // State register.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) state <= IDLE;
        else         state <= state_nxt;
    end

    // Next-state and status outputs; completion is judged on next-cycle counts.
    always_comb begin
        state_nxt   = state;
        cmd_ready_o = 1'b0;
        busy_o      = 1'b0;
        done_o      = 1'b0;
        case (state)
            IDLE: begin
                cmd_ready_o = 1'b1;
                if (cmd_valid_i) state_nxt = (cmd_len_i == '0) ? DONE : RUN;
            end
            RUN: begin
                busy_o = 1'b1;
                if (issued_nxt == job_len) state_nxt = (outst_nxt == '0) ? DONE : DRAIN;
            end
            DRAIN: begin
                busy_o = 1'b1;
                if (outst_nxt == '0) state_nxt = DONE;
            end
            DONE: begin
                done_o    = 1'b1;
                state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    // Job registers, issue/outstanding counters and sticky error.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            job_we      <= 1'b0;
            job_base    <= '0;
            job_len     <= '0;
            issued_cnt  <= '0;
            outstanding <= '0;
            err_q       <= 1'b0;
        end else begin
            outstanding <= outst_nxt;
            if (cmd_fire) begin
                job_we     <= cmd_we_i;
                job_base   <= cmd_addr_i;
                job_len    <= cmd_len_i;
                issued_cnt <= '0;
                err_q      <= 1'b0;
            end else begin
                issued_cnt <= issued_nxt;
                if (obi_rvalid_i && obi_err_i) err_q <= 1'b1;
            end
        end
    end

    // Read FIFO pointers and fill level; a pop frees its slot from the next cycle.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            fifo_count <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + PW'(1);
            if (pop)  rd_ptr <= rd_ptr + PW'(1);
            if (push && !pop)      fifo_count <= fifo_count + CW'(1);
            else if (!push && pop) fifo_count <= fifo_count - CW'(1);
        end
    end

    // Read FIFO storage; error responses are stored like any other.
    always_ff @(posedge clk_i) begin
        if (push) fifo_mem[wr_ptr] <= obi_rdata_i;
    end

endmodule

// File: tb/tb_cnn_obi_mgr.sv
// Testbench for cnn_obi_mgr: OBI memory/responder model, stream producer and
// consumer, table of jobs, hand-written corner cases and random jobs.
module tb_cnn_obi_mgr;
  localparam int AW = 32;
  localparam int DW = 32;
  localparam int LW = 16;
  localparam int MAX_OUTST = 2;
  localparam int FIFO_DEPTH = 4;

  logic clk_i = 1'b0;
  logic rst_ni = 1'b0;
  logic cmd_valid_i = 1'b0, cmd_ready_o, cmd_we_i = 1'b0;
  logic [AW-1:0] cmd_addr_i = '0;
  logic [LW-1:0] cmd_len_i = '0;
  logic busy_o, done_o, err_o;
  logic [DW-1:0] rd_data_o;
  logic rd_valid_o, rd_ready_i = 1'b0;
  logic [DW-1:0] wr_data_i = '0;
  logic wr_valid_i = 1'b0, wr_ready_o;
  logic obi_req_o, obi_gnt_i = 1'b0;
  logic [AW-1:0] obi_addr_o;
  logic obi_we_o;
  logic [DW/8-1:0] obi_be_o;
  logic [DW-1:0] obi_wdata_o;
  logic obi_rvalid_i = 1'b0;
  logic [DW-1:0] obi_rdata_i = '0;
  logic obi_err_i = 1'b0;
  logic [1:0] dbg_state;

  // clock / reset
  always #5 clk_i = ~clk_i;

  cnn_obi_mgr #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .LEN_WIDTH(LW),
                .MAX_OUTST(MAX_OUTST), .FIFO_DEPTH(FIFO_DEPTH)) dut (
    .clk_i(clk_i), .rst_ni(rst_ni),
    .cmd_valid_i(cmd_valid_i), .cmd_ready_o(cmd_ready_o), .cmd_we_i(cmd_we_i),
    .cmd_addr_i(cmd_addr_i), .cmd_len_i(cmd_len_i),
    .busy_o(busy_o), .done_o(done_o), .err_o(err_o),
    .rd_data_o(rd_data_o), .rd_valid_o(rd_valid_o), .rd_ready_i(rd_ready_i),
    .wr_data_i(wr_data_i), .wr_valid_i(wr_valid_i), .wr_ready_o(wr_ready_o),
    .obi_req_o(obi_req_o), .obi_gnt_i(obi_gnt_i), .obi_addr_o(obi_addr_o),
    .obi_we_o(obi_we_o), .obi_be_o(obi_be_o), .obi_wdata_o(obi_wdata_o),
    .obi_rvalid_i(obi_rvalid_i), .obi_rdata_i(obi_rdata_i), .obi_err_i(obi_err_i),
    .dbg_state(dbg_state)
  );

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: actual=%0h required=%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // scoreboard / model state
  typedef struct {
    logic [DW-1:0] data;
    logic          err;
    int unsigned   due;
  } rsp_t;

  rsp_t          rsp_q[$];
  logic [DW-1:0] exp_q[$];
  logic [DW-1:0] wr_src_q[$];
  logic [DW-1:0] wr_words[$];
  logic [DW-1:0] mem_model [logic [AW-1:0]];

  bit          job_we = 1'b0;
  logic [AW-1:0] job_base = '0;
  int          grant_cnt = 0, wr_pulses = 0, done_cnt = 0, out_m = 0, lvl = 0;
  int          gnt_pct = 100, rdy_pct = 100, wgap_pct = 0, lat_min = 1, lat_max = 1, err_at = -1;
  bit          hold_rdy = 1'b0, wr_take = 1'b0, prev_pending = 1'b0, prev_we = 1'b0;
  logic [AW-1:0] prev_addr = '0;
  logic [DW-1:0] prev_wdata = '0;
  int unsigned cyc = 0;

  function automatic logic [DW-1:0] mem_rd(input logic [AW-1:0] a);
    if (mem_model.exists(a)) return mem_model[a];
    return a ^ 32'h5A5A_C3C3;
  endfunction

  // OBI subordinate, stream producer/consumer and protocol monitor
  initial begin
    forever begin
      @(posedge clk_i);
      #1;
      cyc++;
      if (!rst_ni) begin
        obi_rvalid_i = 1'b0; obi_rdata_i = '0; obi_err_i = 1'b0; obi_gnt_i = 1'b0;
        wr_valid_i = 1'b0; wr_take = 1'b0; rd_ready_i = 1'b0;
      end else begin
        if (rsp_q.size() > 0 && rsp_q[0].due <= cyc) begin
          rsp_t r;
          r = rsp_q.pop_front();
          obi_rvalid_i = 1'b1; obi_rdata_i = r.data; obi_err_i = r.err;
        end else begin
          obi_rvalid_i = 1'b0; obi_rdata_i = '0; obi_err_i = 1'b0;
        end
        obi_gnt_i  = int'($urandom_range(99)) < gnt_pct;
        rd_ready_i = !hold_rdy && (int'($urandom_range(99)) < rdy_pct);
        if (wr_take) begin
          wr_valid_i = 1'b0;
          wr_take = 1'b0;
        end
        if (!wr_valid_i && wr_src_q.size() > 0 && int'($urandom_range(99)) >= wgap_pct) begin
          wr_valid_i = 1'b1;
          wr_data_i  = wr_src_q[0];
        end
      end
      @(negedge clk_i);
      if (!rst_ni) begin
        prev_pending = 1'b0;
      end else begin
        if (prev_pending) begin
          chk("req_held", obi_req_o, 1);
          chk("addr_held", obi_addr_o, prev_addr);
          if (prev_we) chk("wdata_held", obi_wdata_o, prev_wdata);
        end
        prev_pending = obi_req_o && !obi_gnt_i;
        prev_addr = obi_addr_o; prev_wdata = obi_wdata_o; prev_we = obi_we_o;
        chk("rd_valid", rd_valid_o, lvl != 0);
        if (obi_req_o && obi_gnt_i) begin
          logic [AW-1:0] ea;
          rsp_t r;
          ea = job_base + AW'(grant_cnt * 4);
          chk("obi_addr", obi_addr_o, ea);
          chk("obi_we", obi_we_o, job_we);
          chk("obi_be", obi_be_o, 4'hF);
          out_m++;
          chk("outst_limit", out_m <= MAX_OUTST, 1);
          if (!job_we) chk("fifo_credit", out_m + lvl <= FIFO_DEPTH, 1);
          if (job_we) begin
            mem_model[obi_addr_o] = obi_wdata_o;
            chk("wr_ready_on_gnt", wr_ready_o, 1);
          end
          r.data = job_we ? '0 : mem_rd(obi_addr_o);
          r.err  = (grant_cnt == err_at);
          r.due  = cyc + $urandom_range(lat_max, lat_min);
          rsp_q.push_back(r);
          grant_cnt++;
        end else begin
          chk("wr_ready_no_gnt", wr_ready_o, 0);
        end
        if (wr_ready_o) begin
          wr_pulses++;
          if (wr_valid_i) begin
            wr_take = 1'b1;
            if (wr_src_q.size() > 0) void'(wr_src_q.pop_front());
          end
        end
        if (obi_rvalid_i) begin
          out_m--;
          if (!job_we) lvl++;
        end
        if (rd_valid_o && rd_ready_i) begin
          if (exp_q.size() == 0) chk("rd_extra_word", 1, 0);
          else chk("rd_data", rd_data_o, exp_q.pop_front());
          lvl--;
        end
        if (done_o) done_cnt++;
      end
    end
  end

  // driver tasks
  task automatic start_cmd(input bit we, input logic [AW-1:0] addr, input int len);
    job_we = we; job_base = addr; grant_cnt = 0; wr_pulses = 0; done_cnt = 0;
    wr_words.delete();
    for (int i = 0; i < len; i++) begin
      logic [AW-1:0] a;
      logic [DW-1:0] w;
      a = addr + AW'(i * 4);
      if (we) begin
        w = $urandom();
        wr_words.push_back(w);
        wr_src_q.push_back(w);
      end else begin
        exp_q.push_back(mem_rd(a));
      end
    end
    @(posedge clk_i);
    #2;
    cmd_valid_i = 1'b1; cmd_we_i = we; cmd_addr_i = addr; cmd_len_i = LW'(len);
    @(negedge clk_i);
    chk("cmd_ready", cmd_ready_o, 1);
    @(posedge clk_i);
    #2;
    cmd_valid_i = 1'b0;
  endtask

  task automatic finish_job(input int exp_grants, input int exp_dones);
    int n;
    n = 0;
    while (done_cnt == 0 && n < 3000) begin @(negedge clk_i); #1; n++; end
    chk("done_seen", done_cnt != 0, 1);
    n = 0;
    while (exp_q.size() != 0 && n < 3000) begin @(negedge clk_i); #1; n++; end
    chk("rd_drained", exp_q.size(), 0);
    repeat (3) begin @(negedge clk_i); #1; end
    chk("done_count", done_cnt, exp_dones);
    chk("grants", grant_cnt, exp_grants);
    chk("busy_after", busy_o, 0);
    chk("outst_zero", out_m, 0);
    if (job_we) begin
      chk("wr_pulses", wr_pulses, exp_grants);
      for (int i = 0; i < wr_words.size(); i++)
        chk("mem_wr", mem_rd(job_base + AW'(i * 4)), wr_words[i]);
    end
  endtask

  task automatic chk_reset_outputs(input string tag);
    chk({tag, "_cmd_ready"}, cmd_ready_o, 1);
    chk({tag, "_busy"}, busy_o, 0);
    chk({tag, "_done"}, done_o, 0);
    chk({tag, "_err"}, err_o, 0);
    chk({tag, "_rd_valid"}, rd_valid_o, 0);
    chk({tag, "_rd_data"}, rd_data_o, 0);
    chk({tag, "_wr_ready"}, wr_ready_o, 0);
    chk({tag, "_req"}, obi_req_o, 0);
    chk({tag, "_addr"}, obi_addr_o, 0);
    chk({tag, "_we"}, obi_we_o, 0);
    chk({tag, "_be"}, obi_be_o, 0);
    chk({tag, "_wdata"}, obi_wdata_o, 0);
  endtask

  typedef struct {
    bit            we;
    logic [AW-1:0] addr;
    int            len;
    int            gnt;
    int            rdy;
    int            wgap;
    int            lat;
    int            exp_grants;
    int            exp_dones;
  } vec_t;

  vec_t vecs[6];

  initial begin
    vecs[0] = '{1'b0, 32'h0000_1000, 4, 100, 100, 0, 1, 4, 1};
    vecs[1] = '{1'b1, 32'h0000_2000, 3, 35, 100, 50, 1, 3, 1};
    vecs[2] = '{1'b0, 32'hFFFF_FFF8, 4, 70, 60, 0, 2, 4, 1};
    vecs[3] = '{1'b1, 32'h0000_3000, 6, 100, 100, 0, 3, 6, 1};
    vecs[4] = '{1'b0, 32'h0000_2000, 3, 100, 100, 0, 1, 3, 1};
    vecs[5] = '{1'b0, 32'h0000_7000, 1, 50, 50, 0, 1, 1, 1};

    // reset state
    repeat (3) @(negedge clk_i);
    chk_reset_outputs("reset");
    rst_ni = 1'b1;
    repeat (2) @(negedge clk_i);

    // table of jobs
    for (int v = 0; v < 6; v++) begin
      gnt_pct = vecs[v].gnt; rdy_pct = vecs[v].rdy; wgap_pct = vecs[v].wgap;
      lat_min = vecs[v].lat; lat_max = vecs[v].lat;
      start_cmd(vecs[v].we, vecs[v].addr, vecs[v].len);
      finish_job(vecs[v].exp_grants, vecs[v].exp_dones);
    end
    gnt_pct = 100; rdy_pct = 100; wgap_pct = 0; lat_min = 1; lat_max = 1;

    // zero-length command: done on the cycle after acceptance, no traffic
    start_cmd(1'b0, 32'h0000_4000, 0);
    @(negedge clk_i);
    chk("len0_done", done_o, 1);
    chk("len0_req", obi_req_o, 0);
    finish_job(0, 1);

    // read back-pressure: fetching stops at FIFO depth
    hold_rdy = 1'b1;
    start_cmd(1'b0, 32'h0000_8000, 8);
    repeat (20) @(negedge clk_i);
    #1;
    chk("bp_grants_max", grant_cnt <= FIFO_DEPTH, 1);
    chk("bp_req_low", obi_req_o, 0);
    chk("bp_fifo_full", rd_valid_o, 1);
    hold_rdy = 1'b0;
    finish_job(8, 1);

    // error on the second response: job completes, err sticky until next command
    err_at = 1;
    start_cmd(1'b0, 32'h0000_5000, 3);
    finish_job(3, 1);
    chk("err_set", err_o, 1);
    err_at = -1;
    start_cmd(1'b0, 32'h0000_5100, 0);
    @(negedge clk_i);
    chk("err_cleared", err_o, 0);
    finish_job(0, 1);

    // reset in the middle of a read job with two responses outstanding
    lat_min = 4; lat_max = 4;
    start_cmd(1'b0, 32'h0000_6000, 8);
    begin
      int n;
      n = 0;
      while (out_m < 2 && n < 50) begin @(negedge clk_i); #1; n++; end
    end
    chk("two_outstanding", out_m, 2);
    rst_ni = 1'b0;
    rsp_q.delete(); exp_q.delete(); wr_src_q.delete();
    out_m = 0; lvl = 0; done_cnt = 0;
    #1;
    chk_reset_outputs("midreset");
    repeat (3) begin
      @(negedge clk_i);
      chk("midreset_no_done", done_o, 0);
    end
    rst_ni = 1'b1;
    lat_min = 1; lat_max = 1;
    repeat (2) @(negedge clk_i);
    start_cmd(1'b0, 32'h0000_6000, 4);
    finish_job(4, 1);

    // random jobs
    for (int j = 0; j < 8; j++) begin
      bit            we;
      logic [AW-1:0] a;
      int            len;
      we = 1'($urandom_range(1));
      a = $urandom();
      a[1:0] = 2'b00;
      len = $urandom_range(12, 1);
      gnt_pct = $urandom_range(100, 30);
      rdy_pct = $urandom_range(100, 20);
      wgap_pct = $urandom_range(60);
      lat_min = 1;
      lat_max = $urandom_range(3, 1);
      start_cmd(we, a, len);
      finish_job(len, 1);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  // global watchdog
  initial begin
    #2000000;
    $display("FAIL watchdog: actual=timeout required=finish");
    $display("Simulation finished: %0d checks, %0d errors", checks, errors + 1);
    $fatal(1, "watchdog");
  end
endmodule
